// File: rtl/pio_pkg.sv
// Shared types and constants for the WS2812 PIO sequencer.
package pio_pkg;

  // PIO action codes driven on pio_action.
  localparam logic [5:0] ACT_NONE = 6'd0;
  localparam logic [5:0] ACT_LOAD = 6'd1;
  localparam logic [5:0] ACT_PUSH = 6'd4;

  // ROM address width and config word layout: [35:32] action, [31:0] data.
  localparam int ADDR_W      = 5;
  localparam int PROG_W      = 16;
  localparam int CONF_ACT_W  = 4;
  localparam int CONF_DATA_W = 32;
  localparam int CONF_W      = CONF_ACT_W + CONF_DATA_W;

  typedef enum logic [2:0] {
    LOAD_PROG,
    LOAD_CONF,
    IDLE,
    STREAM,
    GAP
  } seq_state_t;

endpackage

// File: rtl/pio_ws_sequencer_if.sv
// Pixel stream and PIO bus between the sequencer, upstream pattern logic
// and the pio block. The sequencer uses the master modport.
//
// Pixel handshake: a pixel is consumed in a cycle where pix_ready=1, and
// pix_ready is only ever high while pix_valid was high at the preceding
// clock edge. Upstream holds pix_data stable while pix_valid=1 and
// pix_ready=0. Pushes to the PIO TX FIFO are never back-to-back, so
// pix_ready is never high in two consecutive cycles.
interface pio_ws_sequencer_if;
  import pio_pkg::*;

  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic [5:0]  pio_action;
  logic [31:0] pio_din;
  logic [4:0]  pio_index;
  logic [1:0]  pio_mindex;
  logic [3:0]  tx_full;
  seq_state_t  state;      // sequencer FSM state, for observation only

  modport master (
    input  pix_valid, pix_data, tx_full,
    output pix_ready, pio_action, pio_din, pio_index, pio_mindex, state
  );

  modport slave (
    output pix_valid, pix_data, tx_full,
    input  pix_ready, pio_action, pio_din, pio_index, pio_mindex, state
  );

endinterface

// File: rtl/pio_rom_loader.sv
// Walks a registered-read ROM from address 0 to LEN-1 while enabled and
// reports each word one cycle after its address, with a done pulse on the
// last word.
module pio_rom_loader
  import pio_pkg::*;
#(
  parameter int LEN    = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] issue_index,
  output logic [DATA_W-1:0] issue_data,
  output logic              done
);

  logic [ADDR_W:0]   cnt;
  logic              pend;
  logic [ADDR_W-1:0] pend_idx;
  logic              issue;

  assign issue       = en && (cnt < (ADDR_W+1)'(LEN));
  assign rom_addr    = cnt[ADDR_W-1:0];
  assign issue_valid = pend;
  assign issue_index = pend_idx;
  assign issue_data  = rom_data;
  assign done        = pend && (pend_idx == ADDR_W'(LEN - 1));

  // Address counter; remembers which index the ROM is returning next cycle.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      cnt      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        cnt      <= cnt + 1'b1;
        pend_idx <= cnt[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pio_ws_sequencer.sv
// Loads the PIO program and config, then streams WS2812 frames into the
// selected state machine's TX FIFO with a latch gap after each frame.
module pio_ws_sequencer
  import pio_pkg::*;
#(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 5,
  parameter int NUM_PIX  = 16,
  parameter int GAP_CYC  = 1250,
  parameter int SM_IDX   = 0
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  output logic [ADDR_W-1:0]   prog_addr,
  input  logic [PROG_W-1:0]   prog_data,
  output logic [ADDR_W-1:0]   conf_addr,
  input  logic [CONF_W-1:0]   conf_data,
  input  logic                frame_start,
  output logic                cfg_done,
  output logic                busy,
  output logic [7:0]          stall_cnt,
  pio_ws_sequencer_if.master  bus
);

  if (GAP_CYC < 1 || GAP_CYC > 65535) begin : g_gap_range
    $error("GAP_CYC must be within 1..65535");
  end

  seq_state_t         state, state_n;
  logic [7:0]         pix_cnt, pix_cnt_n;
  logic [15:0]        gap_cnt, gap_cnt_n;
  logic [5:0]         action_n;
  logic [31:0]        din_n;
  logic [4:0]         index_n;
  logic               ready_n;
  logic               conf_done_q;
  logic               sm_full, push;
  logic               prog_v, prog_done, conf_v, conf_done;
  logic [ADDR_W-1:0]  prog_idx, conf_idx;
  logic [PROG_W-1:0]  prog_word;
  logic [CONF_W-1:0]  conf_word;

  pio_rom_loader #(.LEN(PROG_LEN), .DATA_W(PROG_W)) u_prog_loader (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .en          (state == LOAD_PROG),
    .rom_addr    (prog_addr),
    .rom_data    (prog_data),
    .issue_valid (prog_v),
    .issue_index (prog_idx),
    .issue_data  (prog_word),
    .done        (prog_done)
  );

  pio_rom_loader #(.LEN(CONF_LEN), .DATA_W(CONF_W)) u_conf_loader (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .en          (state == LOAD_CONF),
    .rom_addr    (conf_addr),
    .rom_data    (conf_data),
    .issue_valid (conf_v),
    .issue_index (conf_idx),
    .issue_data  (conf_word),
    .done        (conf_done)
  );

  // The cycle after a push (pix_ready high) is always idle so tx_full has
  // time to reflect the word just pushed.
  assign sm_full   = bus.tx_full[SM_IDX];
  assign push      = (state == STREAM) && bus.pix_valid && !sm_full && !bus.pix_ready;
  assign bus.state = state;

  // State and counter registers.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state   <= LOAD_PROG;
      pix_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      pix_cnt <= pix_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Next state and next values of the registered PIO/handshake outputs.
  always_comb begin
    state_n   = state;
    pix_cnt_n = pix_cnt;
    gap_cnt_n = gap_cnt;
    action_n  = ACT_NONE;
    din_n     = '0;
    index_n   = '0;
    ready_n   = 1'b0;
    case (state)
      LOAD_PROG: begin
        if (prog_v) begin
          action_n = ACT_LOAD;
          index_n  = prog_idx;
          din_n    = {16'h0000, prog_word};
        end
        if (prog_done) state_n = LOAD_CONF;
      end
      LOAD_CONF: begin
        if (conf_v) begin
          action_n = {2'b00, conf_word[CONF_W-1:CONF_DATA_W]};
          index_n  = conf_idx;
          din_n    = conf_word[CONF_DATA_W-1:0];
        end
        if (conf_done) state_n = IDLE;
      end
      IDLE: begin
        if (frame_start) begin
          state_n   = STREAM;
          pix_cnt_n = '0;
        end
      end
      STREAM: begin
        if (push) begin
          action_n  = ACT_PUSH;
          din_n     = {bus.pix_data, 8'h00};
          ready_n   = 1'b1;
          pix_cnt_n = pix_cnt + 8'd1;
          if (pix_cnt == 8'(NUM_PIX - 1)) begin
            state_n   = GAP;
            gap_cnt_n = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 16'(GAP_CYC - 1)) state_n = IDLE;
        else                              gap_cnt_n = gap_cnt + 16'd1;
      end
      default: state_n = LOAD_PROG;
    endcase
  end

  // Registered outputs; cfg_done follows the last config action by a cycle.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      bus.pio_action <= ACT_NONE;
      bus.pio_din    <= '0;
      bus.pio_index  <= '0;
      bus.pio_mindex <= '0;
      bus.pix_ready  <= 1'b0;
      busy           <= 1'b0;
      conf_done_q    <= 1'b0;
      cfg_done       <= 1'b0;
    end else begin
      bus.pio_action <= action_n;
      bus.pio_din    <= din_n;
      bus.pio_index  <= index_n;
      bus.pio_mindex <= (action_n != ACT_NONE) ? 2'(SM_IDX) : 2'd0;
      bus.pix_ready  <= ready_n;
      busy           <= (state_n == STREAM) || (state_n == GAP);
      conf_done_q    <= conf_done;
      cfg_done       <= cfg_done | conf_done_q;
    end
  end

  // Saturating count of STREAM cycles held off by a full TX FIFO.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == STREAM) && bus.pix_valid && sm_full && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pio_ws_sequencer.sv
// Directed bench for pio_ws_sequencer: ROM load, framing, stalls, reset.
module tb_pio_ws_sequencer;
  import pio_pkg::*;

  localparam int PROG_LEN = 32;
  localparam int CONF_LEN = 5;
  localparam int NUM_PIX  = 16;
  localparam int GAP_CYC  = 1250;
  localparam int SM_IDX   = 2;
  localparam logic [3:0] FULL_OTHERS = 4'b1011;  // every FIFO full except ours
  localparam logic [3:0] FULL_ALL    = 4'b1111;

  typedef struct {
    logic [23:0] pix;
    logic [31:0] exp_din;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  prog_addr, conf_addr;
  logic [15:0] prog_data = '0;
  logic [35:0] conf_data = '0;
  logic        frame_start = 1'b0;
  logic        cfg_done, busy;
  logic [7:0]  stall_cnt;

  always #20 clk_25mhz = ~clk_25mhz;

  pio_ws_sequencer_if bus_if ();

  pio_ws_sequencer #(
    .PROG_LEN (PROG_LEN),
    .CONF_LEN (CONF_LEN),
    .NUM_PIX  (NUM_PIX),
    .GAP_CYC  (GAP_CYC),
    .SM_IDX   (SM_IDX)
  ) dut (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .conf_addr   (conf_addr),
    .conf_data   (conf_data),
    .frame_start (frame_start),
    .cfg_done    (cfg_done),
    .busy        (busy),
    .stall_cnt   (stall_cnt),
    .bus         (bus_if.master)
  );

  // Registered-read ROM models.
  logic [15:0] prog_rom [PROG_LEN];
  logic [35:0] conf_rom [CONF_LEN];
  always @(posedge clk_25mhz) prog_data <= prog_rom[prog_addr];
  always @(posedge clk_25mhz) conf_data <= conf_rom[conf_addr];

  // ---------------- bench state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_no  = 0;
  int          push_cnt = 0;
  int          last_push_cyc = 0;
  int          pix_idx = 0;
  bit          prev_push = 0;
  bit          drv_en = 0, valid_rand = 0, spam_en = 0, sb_en = 0;
  logic [23:0] frame_pix [NUM_PIX];
  logic [31:0] exp_q [$];
  vec_t        vecs [NUM_PIX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: observe outputs at the falling edge, then drive upstream.
  task automatic cycle();
    @(negedge clk_25mhz);
    cyc_no++;
    if (bus_if.pio_action == ACT_PUSH) begin
      check("push_ready", 64'(bus_if.pix_ready), 64'd1);
      check("push_mindex", 64'(bus_if.pio_mindex), 64'(SM_IDX));
      check("push_with_valid", 64'(bus_if.pix_valid), 64'd1);
      check("push_not_back_to_back", 64'(prev_push), 64'd0);
      if (sb_en) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("push_order_din", 64'(bus_if.pio_din), 64'(exp_q.pop_front()));
      end
      push_cnt++;
      last_push_cyc = cyc_no;
    end else begin
      check("ready_without_push", 64'(bus_if.pix_ready), 64'd0);
    end
    prev_push = (bus_if.pio_action == ACT_PUSH);
    if (bus_if.pix_ready) pix_idx++;
    if (drv_en && pix_idx < NUM_PIX) begin
      bus_if.pix_valid = valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.pix_data  = frame_pix[pix_idx];
    end else begin
      bus_if.pix_valid = 1'b0;
    end
    if (spam_en) frame_start = busy && ($urandom_range(0, 2) == 0);
  endtask

  task automatic start_frame();
    pix_idx  = 0;
    push_cnt = 0;
    drv_en   = 1;
    frame_start = 1'b1;
    cycle();
    if (!spam_en) frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int w;
    w = 0;
    while (busy && w < budget) begin
      cycle();
      w++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_action"}, 64'(bus_if.pio_action), 64'd0);
    check({tag, "_din"},    64'(bus_if.pio_din), 64'd0);
    check({tag, "_index"},  64'(bus_if.pio_index), 64'd0);
    check({tag, "_mindex"}, 64'(bus_if.pio_mindex), 64'd0);
    check({tag, "_ready"},  64'(bus_if.pix_ready), 64'd0);
    check({tag, "_cfg_done"}, 64'(cfg_done), 64'd0);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_stall"},  64'(stall_cnt), 64'd0);
    check({tag, "_prog_addr"}, 64'(prog_addr), 64'd0);
    check({tag, "_conf_addr"}, 64'(conf_addr), 64'd0);
  endtask

  // Program words then config words must come out in order, back to back.
  task automatic check_loads();
    int w;
    logic [5:0] exp_act;
    w = 0;
    while (bus_if.pio_action != ACT_LOAD && w < 10) begin
      cycle();
      w++;
    end
    check("load_seen", 64'(bus_if.pio_action), 64'(ACT_LOAD));
    for (int k = 0; k < PROG_LEN; k++) begin
      check("load_action", 64'(bus_if.pio_action), 64'(ACT_LOAD));
      check("load_index",  64'(bus_if.pio_index), 64'(k));
      check("load_din",    64'(bus_if.pio_din), {48'h0, prog_rom[k]});
      check("load_mindex", 64'(bus_if.pio_mindex), 64'(SM_IDX));
      cycle();
    end
    w = 0;
    while (bus_if.pio_action == ACT_NONE && w < 10) begin
      cycle();
      w++;
    end
    for (int k = 0; k < CONF_LEN; k++) begin
      exp_act = {2'b00, conf_rom[k][35:32]};
      check("conf_action", 64'(bus_if.pio_action), 64'(exp_act));
      check("conf_din",    64'(bus_if.pio_din), 64'(conf_rom[k][31:0]));
      check("conf_mindex", 64'(bus_if.pio_mindex), (exp_act != 0) ? 64'(SM_IDX) : 64'd0);
      check("cfg_done_early", 64'(cfg_done), 64'd0);
      cycle();
    end
    check("cfg_done_rise", 64'(cfg_done), 64'd1);
    check("post_conf_action", 64'(bus_if.pio_action), 64'(ACT_NONE));
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int w, p;
    for (int i = 0; i < PROG_LEN; i++) prog_rom[i] = 16'(16'h1000 + i * 16'h0111);
    conf_rom[0] = {4'h2, 32'h0012_3456};
    conf_rom[1] = {4'h3, 32'hDEAD_BEEF};
    conf_rom[2] = {4'h0, 32'h0000_0001};  // no-op action
    conf_rom[3] = {4'h8, 32'h8000_0000};
    conf_rom[4] = {4'hF, 32'hFFFF_FFFF};

    vecs[0]  = '{24'h00FF00, 32'h00FF0000};
    vecs[1]  = '{24'hFF0000, 32'hFF000000};
    vecs[2]  = '{24'h0000FF, 32'h0000FF00};
    vecs[3]  = '{24'hFFFFFF, 32'hFFFFFF00};
    vecs[4]  = '{24'h000000, 32'h00000000};
    vecs[5]  = '{24'h123456, 32'h12345600};
    vecs[6]  = '{24'hABCDEF, 32'hABCDEF00};
    vecs[7]  = '{24'h800001, 32'h80000100};
    vecs[8]  = '{24'h7F7F7F, 32'h7F7F7F00};
    vecs[9]  = '{24'h010203, 32'h01020300};
    vecs[10] = '{24'hA5A5A5, 32'hA5A5A500};
    vecs[11] = '{24'h5A5A5A, 32'h5A5A5A00};
    vecs[12] = '{24'hC0FFEE, 32'hC0FFEE00};
    vecs[13] = '{24'h000100, 32'h00010000};
    vecs[14] = '{24'hFEDCBA, 32'hFEDCBA00};
    vecs[15] = '{24'h0F0F0F, 32'h0F0F0F00};

    bus_if.pix_valid = 1'b0;
    bus_if.pix_data  = '0;
    bus_if.tx_full   = '0;

    // Power-on reset, then program + config load.
    repeat (3) cycle();
    check_reset_outputs("por");
    reset = 1'b0;
    check_loads();
    repeat (3) cycle();
    check("idle_busy", 64'(busy), 64'd0);

    // Frame 1: table vectors, valid held, only other machines' FIFOs full.
    bus_if.tx_full = FULL_OTHERS;
    for (int i = 0; i < NUM_PIX; i++) frame_pix[i] = vecs[i].pix;
    sb_en = 0;
    valid_rand = 0;
    start_frame();
    p = 0;
    for (int i = 0; i < NUM_PIX; i++) begin
      cycle();
      w = 1;
      while (bus_if.pio_action != ACT_PUSH && w < 8) begin
        cycle();
        w++;
      end
      check("f1_push_seen", 64'(bus_if.pio_action), 64'(ACT_PUSH));
      check("f1_push_din", 64'(bus_if.pio_din), 64'(vecs[i].exp_din));
      if (i > 0) check("f1_push_spacing", 64'(cyc_no - p), 64'd2);
      p = cyc_no;
    end
    wait_idle("f1_busy_fall", GAP_CYC + 200);
    check("f1_gap_len", 64'(cyc_no - last_push_cyc), 64'(GAP_CYC));
    check("f1_push_count", 64'(push_cnt), 64'(NUM_PIX));
    check("f1_stall_other_sm", 64'(stall_cnt), 64'd0);

    // Frame 2: stall on our FIFO for 10 cycles, then long enough to saturate.
    exp_q.delete();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(vecs[i].exp_din);
    sb_en = 1;
    start_frame();
    w = 0;
    while (push_cnt < 3 && w < 20) begin
      cycle();
      w++;
    end
    check("f2_pre_pushes", 64'(push_cnt), 64'd3);
    bus_if.tx_full = FULL_ALL;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("f2_stall_no_push", 64'(bus_if.pio_action == ACT_PUSH), 64'd0);
    end
    check("f2_stall_cnt_10", 64'(stall_cnt), 64'd10);
    bus_if.tx_full = FULL_OTHERS;
    cycle();
    check("f2_push_resume", 64'(bus_if.pio_action), 64'(ACT_PUSH));
    bus_if.tx_full = FULL_ALL;
    repeat (300) cycle();
    check("f2_stall_saturate", 64'(stall_cnt), 64'hFF);
    bus_if.tx_full = FULL_OTHERS;
    wait_idle("f2_busy_fall", GAP_CYC + 200);
    check("f2_push_count", 64'(push_cnt), 64'(NUM_PIX));
    check("f2_sb_drained", 64'(exp_q.size()), 64'd0);

    // Frame 3: random pixels, toggling valid, frame_start spammed while busy.
    for (int i = 0; i < NUM_PIX; i++) begin
      frame_pix[i] = 24'($urandom);
      exp_q.push_back({frame_pix[i], 8'h00});
    end
    valid_rand = 1;
    spam_en = 1;
    start_frame();
    wait_idle("f3_busy_fall", GAP_CYC + 2000);
    spam_en = 0;
    frame_start = 1'b0;
    valid_rand = 0;
    check("f3_push_count", 64'(push_cnt), 64'(NUM_PIX));
    check("f3_sb_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) cycle();
    check("f3_no_queued_frame", 64'(busy), 64'd0);
    check("f3_no_extra_push", 64'(push_cnt), 64'(NUM_PIX));

    // Frame 4: reset at the 7th push forces a full reload.
    for (int i = 0; i < NUM_PIX; i++) begin
      frame_pix[i] = vecs[i].pix;
      exp_q.push_back(vecs[i].exp_din);
    end
    start_frame();
    w = 0;
    while (push_cnt < 7 && w < 40) begin
      cycle();
      w++;
    end
    check("f4_pushes_before_reset", 64'(push_cnt), 64'd7);
    check("f4_stall_before_reset", 64'(stall_cnt), 64'hFF);
    reset = 1'b1;
    drv_en = 0;
    cycle();
    exp_q.delete();
    check_reset_outputs("mid_reset");
    cycle();
    reset = 1'b0;
    check_loads();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_no);
    $fatal(1, "watchdog");
  end

endmodule
